// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: shared channel tags, Q8 coefficients and types for the Y/Cb/Cr-to-RGB pipeline.
package ycbcr_pkg;
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_X = 2'd3;
  localparam int CB_COEF_R = 0;
  localparam int CB_COEF_G = -88;
  localparam int CB_COEF_B = 454;
  localparam int CR_COEF_R = 359;
  localparam int CR_COEF_G = -183;
  localparam int CR_COEF_B = 0;
  localparam int FRAC_BITS = 8;
  localparam int ROUND_K = 128;
  typedef enum logic [1:0] {EXP_R, EXP_G, EXP_B} pack_state_e;
  function automatic logic signed [8:0] center(input logic [7:0] x);
    return $signed({1'b0, x}) - 9'sd128;
  endfunction
endpackage

// File: rtl/ycc_round_clamp.sv
// ycc_round_clamp: round a signed Q8 value to nearest integer and clamp it to 0..255.
module ycc_round_clamp
  import ycbcr_pkg::*;
#(
  parameter int INT_W = 20
) (
  input  logic signed [INT_W-1:0] sum,
  output logic        [7:0]       val
);
  logic [INT_W:0] r;
  logic [INT_W-FRAC_BITS:0] t;
  assign r = {sum[INT_W-1], sum} + (INT_W+1)'(ROUND_K);
  assign t = r[INT_W:FRAC_BITS];
  assign val = t[INT_W-FRAC_BITS] ? 8'd0 : (|t[INT_W-FRAC_BITS-1:8]) ? 8'd255 : t[7:0];
endmodule

// File: rtl/ycbcr_to_rgb_stage_cr.sv
// ycbcr_to_rgb_stage_cr: adds the Cr term per channel, rounds/clamps, and packs R,G,B into one pixel.
module ycbcr_to_rgb_stage_cr
  import ycbcr_pkg::*;
#(
  parameter int ACC_W  = 17,
  parameter int INT_W  = 20,
  parameter int COEF_R = CR_COEF_R,
  parameter int COEF_G = CR_COEF_G,
  parameter int COEF_B = CR_COEF_B
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic [1:0]              state_i,
  input  logic [7:0]              cr_data_i,
  input  logic signed [ACC_W-1:0] accum_data_i,
  output logic                    valid_o,
  output logic [23:0]             rgb_o,
  output logic                    seq_err_o
);
  logic signed [8:0]       cr_s1;
  logic signed [INT_W-1:0] acc_s1;
  logic [1:0]              st_s1;
  logic                    v_s1;
  logic signed [INT_W-1:0] coef, cr_ext, sum;
  logic [7:0]              ch_val_d, ch_val;
  logic [1:0]              ch_state;
  logic                    ch_valid;
  pack_state_e             st_q, st_d;
  logic [7:0]              r_q, r_d, g_q, g_d;
  logic [23:0]             rgb_d;
  logic                    valid_d, err_d;
  always_ff @(posedge clk) begin
    v_s1 <= rst ? 1'b0 : valid_i;
    if (valid_i) begin
      cr_s1  <= center(cr_data_i);
      acc_s1 <= {{(INT_W-ACC_W){accum_data_i[ACC_W-1]}}, accum_data_i};
      st_s1  <= state_i;
    end
  end
  always_comb begin
    coef = st_s1 == CH_R ? INT_W'(COEF_R) :
           st_s1 == CH_G ? INT_W'(COEF_G) :
           st_s1 == CH_B ? INT_W'(COEF_B) : '0;
    cr_ext = {{(INT_W-9){cr_s1[8]}}, cr_s1};
    sum = acc_s1 + cr_ext * coef;
  end
  ycc_round_clamp #(.INT_W(INT_W)) u_rc (
    .sum(sum),
    .val(ch_val_d)
  );
  always_ff @(posedge clk) begin
    ch_valid <= rst ? 1'b0 : v_s1;
    if (v_s1) begin
      ch_val   <= ch_val_d;
      ch_state <= st_s1;
    end
  end
  // A stray R tag always restarts the pixel; any other out-of-order tag abandons it.
  always_comb begin
    st_d    = st_q;
    r_d     = r_q;
    g_d     = g_q;
    rgb_d   = rgb_o;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (ch_valid) begin
      case (st_q)
        EXP_R: begin
          err_d = ch_state != CH_R;
          r_d   = ch_state == CH_R ? ch_val : r_q;
          st_d  = ch_state == CH_R ? EXP_G : EXP_R;
        end
        EXP_G: begin
          err_d = ch_state != CH_G;
          g_d   = ch_state == CH_G ? ch_val : g_q;
          r_d   = ch_state == CH_R ? ch_val : r_q;
          st_d  = ch_state == CH_G ? EXP_B : ch_state == CH_R ? EXP_G : EXP_R;
        end
        EXP_B: begin
          err_d   = ch_state != CH_B;
          valid_d = ch_state == CH_B;
          rgb_d   = ch_state == CH_B ? {r_q, g_q, ch_val} : rgb_o;
          r_d     = ch_state == CH_R ? ch_val : r_q;
          st_d    = ch_state == CH_R ? EXP_G : EXP_R;
        end
        default: st_d = EXP_R;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= EXP_R;
      r_q       <= '0;
      g_q       <= '0;
      rgb_o     <= '0;
      valid_o   <= 1'b0;
      seq_err_o <= 1'b0;
    end else begin
      st_q      <= st_d;
      r_q       <= r_d;
      g_q       <= g_d;
      rgb_o     <= rgb_d;
      valid_o   <= valid_d;
      seq_err_o <= err_d;
    end
  end
endmodule

// File: tb/tb_ycbcr_to_rgb_stage_cr.sv
// tb_ycbcr_to_rgb_stage_cr: scoreboard bench; a reference model queues expected pixels and error pulses.
module tb_ycbcr_to_rgb_stage_cr;
  typedef struct {
    int val;
    int cyc;
  } exp_t;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_i = 1'b0;
  logic [1:0]         state_i = 2'd0;
  logic [7:0]         cr_data_i = 8'd0;
  logic signed [16:0] accum_data_i = '0;
  logic               valid_o;
  logic [23:0]        rgb_o;
  logic               seq_err_o;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t pq[$];
  exp_t eq[$];
  exp_t p;
  int   last_rgb = 0;
  int   mst = 0;
  int   mr = 0;
  int   mg = 0;
  ycbcr_to_rgb_stage_cr dut (
    .clk(clk),
    .rst(rst),
    .valid_i(valid_i),
    .state_i(state_i),
    .cr_data_i(cr_data_i),
    .accum_data_i(accum_data_i),
    .valid_o(valid_o),
    .rgb_o(rgb_o),
    .seq_err_o(seq_err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int ch_model(input logic [1:0] tag, input int acc, input int cr);
    int c = tag == 2'd0 ? 359 : tag == 2'd1 ? -183 : 0;
    int t = (acc + (cr - 128) * c + 128) >>> 8;
    return t < 0 ? 0 : t > 255 ? 255 : t;
  endfunction
  task automatic push_err();
    eq.push_back('{1, cyc + 2});
  endtask
  task automatic beat(input logic [1:0] tag, input int acc, input int cr);
    int v;
    valid_i      = 1'b1;
    state_i      = tag;
    accum_data_i = 17'(acc);
    cr_data_i    = 8'(cr);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    v = ch_model(tag, acc, cr);
    case (mst)
      0: if (tag == 2'd0) begin mr = v; mst = 1; end else push_err();
      1: if (tag == 2'd1) begin mg = v; mst = 2; end
         else begin push_err(); mr = v; mst = tag == 2'd0 ? 1 : 0; end
      default: if (tag == 2'd2) begin pq.push_back('{(mr << 16) | (mg << 8) | v, cyc + 2}); mst = 0; end
         else begin push_err(); mr = v; mst = tag == 2'd0 ? 1 : 0; end
    endcase
  endtask
  task automatic pixel(input int acc_r, input int acc_g, input int acc_b, input int cr);
    beat(2'd0, acc_r, cr);
    beat(2'd1, acc_g, cr);
    beat(2'd2, acc_b, cr);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_err", seq_err_o, 0);
    check("rst_rgb", rgb_o, 0);
    mst = 0;
    mr = 0;
    mg = 0;
    last_rgb = 0;
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (pq.size() == 0) check("extra_pix", valid_o, 0);
        else begin
          p = pq.pop_front();
          check("rgb", rgb_o, p.val);
          check("pix_cyc", cyc, p.cyc);
          last_rgb = p.val;
        end
      end else check("rgb_hold", rgb_o, last_rgb);
      if (seq_err_o) begin
        if (eq.size() == 0) check("extra_err", seq_err_o, 0);
        else begin
          p = eq.pop_front();
          check("err_cyc", cyc, p.cyc);
        end
      end
    end
  end
  initial begin
    do_reset(2);
    idle(2);
    pixel(32768, 32768, 32768, 128);
    idle(4);
    check("grey_out", rgb_o, 24'h808080);
    pixel(65280, 65280, 65280, 255);
    idle(4);
    check("sat_out", rgb_o, 24'hFFA4FF);
    pixel(-20000, -20000, -20000, 128);
    pixel(127, 127, 127, 128);
    pixel(128, 128, 128, 128);
    idle(4);
    check("round_out", rgb_o, 24'h010101);
    beat(2'd0, 32768, 128);
    beat(2'd2, 32768, 128);
    pixel(32768, 32768, 32768, 128);
    idle(4);
    beat(2'd0, 40000, 200);
    idle(3);
    beat(2'd1, 30000, 60);
    beat(2'd2, 20000, 90);
    idle(4);
    beat(2'd0, 32768, 128);
    beat(2'd1, 32768, 128);
    do_reset(1);
    beat(2'd2, 32768, 128);
    idle(4);
    beat(2'd0, 10000, 10);
    beat(2'd3, 10000, 10);
    pixel(50000, 25000, 12000, 30);
    idle(4);
    pixel(1000, 2000, 3000, 0);
    pixel(60000, 45000, 30000, 250);
    pixel(-5000, 70000 - 70000, 33000, 100);
    pixel(12345, 23456, 34567, 177);
    for (int i = 0; i < 4; i++)
      pixel(int'($urandom_range(0, 85535)) - 20000, int'($urandom_range(0, 85535)) - 20000,
            int'($urandom_range(0, 85535)) - 20000, int'($urandom_range(0, 255)));
    idle(8);
    check("pend_pix", pq.size(), 0);
    check("pend_err", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
